// File: rtl/ad7760_seq_ctrl_pkg.sv
// rtl/ad7760_seq_ctrl_pkg.sv - shared types and constants for the AD7760 sequencer
package ad7760_seq_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_RST_LO  = 4'd1,
    ST_RST_HI  = 4'd2,
    ST_WR_ADDR = 4'd3,
    ST_GAP_A   = 4'd4,
    ST_WR_VAL  = 4'd5,
    ST_GAP_V   = 4'd6,
    ST_SETTLE  = 4'd7,
    ST_CAPTURE = 4'd8
  } state_e;

  localparam int TMR_W = 16;

  localparam logic [15:0] CTRL1_ADDR = 16'h0001;
  localparam logic [15:0] CTRL2_ADDR = 16'h0002;
  localparam logic [15:0] CTRL1_VAL  = 16'h0000;
  localparam logic [15:0] CTRL2_VAL  = 16'h0022;

endpackage

// File: rtl/ad7760_seq_ctrl_if.sv
// rtl/ad7760_seq_ctrl_if.sv - ADC parallel bus and sample stream bundle
interface ad7760_seq_ctrl_if #(
  parameter int DW = 16
);
  logic          drdy_n;
  logic [DW-1:0] adc_din;
  logic [DW-1:0] adc_dout;
  logic          adc_doe;
  logic          o_rest_n;
  logic          cs_n;
  logic          r_n_w;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;

  modport master (
    input  drdy_n, adc_din, m_ready,
    output adc_dout, adc_doe, o_rest_n, cs_n, r_n_w, m_data, m_valid
  );

  modport slave (
    output drdy_n, adc_din, m_ready,
    input  adc_dout, adc_doe, o_rest_n, cs_n, r_n_w, m_data, m_valid
  );
endinterface

// File: rtl/ad7760_seq_ctrl_drdy_sync_edge.sv
// rtl/ad7760_seq_ctrl_drdy_sync_edge.sv - drdy_n synchroniser with registered falling-edge pulse
module drdy_sync_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic drdy_n_i,
  output logic fall_o
);
  logic s1_q, s2_q, s3_q, fall_q;

  // Sync stages reset high (drdy idle) so release never fakes an edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      s3_q   <= 1'b1;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= drdy_n_i;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      fall_q <= s3_q & ~s2_q;
    end
  end

  assign fall_o = fall_q;
endmodule

// File: rtl/ad7760_seq_ctrl.sv
// rtl/ad7760_seq_ctrl.sv - AD7760 reset, register-write and sample-capture sequencer (MCLK domain)
module ad7760_seq_ctrl
  import ad7760_seq_ctrl_pkg::*;
#(
  parameter int DW         = 16,
  parameter int NUM_CFG    = 2,
  parameter int RST_LO_CYC = 2,
  parameter int RST_HI_CYC = 3,
  parameter int WR_CYC     = 8,
  parameter int GAP_CYC    = 8,
  parameter int SETTLE_CYC = 6
) (
  input  logic              mclk,
  input  logic              i_rest,
  input  logic              command,
  ad7760_seq_ctrl_if.master bus,
  output logic [3:0]        cfg_idx,
  input  logic [2*DW-1:0]   cfg_word,
  output logic [7:0]        ovf_cnt,
  output logic              cfg_done,
  output logic              busy
);

  state_e           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [3:0]       cfg_idx_q, cfg_idx_d;
  logic             rest_n_q, rest_n_d;
  logic             cs_n_q, cs_n_d;
  logic             r_n_w_q, r_n_w_d;
  logic             doe_q, doe_d;
  logic [DW-1:0]    dout_q, dout_d;
  logic [DW-1:0]    m_data_q, m_data_d;
  logic             m_valid_q, m_valid_d;
  logic [7:0]       ovf_q, ovf_d;
  logic             drdy_fall, capture, tmr_zero, last_cfg;

  function automatic logic [TMR_W-1:0] load_of(state_e s);
    case (s)
      ST_RST_LO:           load_of = TMR_W'(RST_LO_CYC - 1);
      ST_RST_HI:           load_of = TMR_W'(RST_HI_CYC - 1);
      ST_WR_ADDR, ST_WR_VAL: load_of = TMR_W'(WR_CYC - 1);
      ST_GAP_A, ST_GAP_V:  load_of = TMR_W'(GAP_CYC - 1);
      ST_SETTLE:           load_of = TMR_W'(SETTLE_CYC - 1);
      default:             load_of = '0;
    endcase
  endfunction

  drdy_sync_edge u_drdy (
    .clk_i    (mclk),
    .rst_i    (i_rest),
    .drdy_n_i (bus.drdy_n),
    .fall_o   (drdy_fall)
  );

  assign tmr_zero = (tmr_q == '0);
  assign last_cfg = (cfg_idx_q == 4'(NUM_CFG - 1));
  assign capture  = drdy_fall && (state_q == ST_CAPTURE);

  always_ff @(posedge mclk or posedge i_rest) begin
    if (i_rest) begin
      state_q   <= ST_IDLE;
      tmr_q     <= '0;
      cfg_idx_q <= '0;
      rest_n_q  <= 1'b1;
      cs_n_q    <= 1'b1;
      r_n_w_q   <= 1'b1;
      doe_q     <= 1'b0;
      dout_q    <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      ovf_q     <= '0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      cfg_idx_q <= cfg_idx_d;
      rest_n_q  <= rest_n_d;
      cs_n_q    <= cs_n_d;
      r_n_w_q   <= r_n_w_d;
      doe_q     <= doe_d;
      dout_q    <= dout_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      ovf_q     <= ovf_d;
    end
  end

  // Command is only sampled at IDLE, SETTLE exit and in CAPTURE; config writes always finish.
  always_comb begin
    state_d   = state_q;
    cfg_idx_d = cfg_idx_q;
    case (state_q)
      ST_IDLE:    if (command) state_d = ST_RST_LO;
      ST_RST_LO:  if (tmr_zero) state_d = ST_RST_HI;
      ST_RST_HI: begin
        cfg_idx_d = '0;
        if (tmr_zero) state_d = ST_WR_ADDR;
      end
      ST_WR_ADDR: if (tmr_zero) state_d = ST_GAP_A;
      ST_GAP_A:   if (tmr_zero) state_d = ST_WR_VAL;
      ST_WR_VAL:  if (tmr_zero) state_d = ST_GAP_V;
      ST_GAP_V: begin
        if (tmr_zero) begin
          if (last_cfg) begin
            state_d = ST_SETTLE;
          end else begin
            cfg_idx_d = cfg_idx_q + 4'd1;
            state_d   = ST_WR_ADDR;
          end
        end
      end
      ST_SETTLE:  if (tmr_zero) state_d = command ? ST_CAPTURE : ST_IDLE;
      ST_CAPTURE: if (!command) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    if (state_d != state_q) tmr_d = load_of(state_d);
    else if (!tmr_zero)     tmr_d = tmr_q - 1'b1;
    else                    tmr_d = tmr_q;
  end

  // Bus outputs are decoded from the next state so the registered pins line up with state_q.
  always_comb begin
    rest_n_d = 1'b1;
    cs_n_d   = 1'b1;
    r_n_w_d  = 1'b1;
    doe_d    = 1'b0;
    dout_d   = '0;
    case (state_d)
      ST_RST_LO: rest_n_d = 1'b0;
      ST_WR_ADDR: begin
        cs_n_d = 1'b0;
        doe_d  = 1'b1;
        dout_d = cfg_word[2*DW-1:DW];
      end
      ST_WR_VAL: begin
        cs_n_d = 1'b0;
        doe_d  = 1'b1;
        dout_d = cfg_word[DW-1:0];
      end
      ST_CAPTURE: begin
        cs_n_d  = 1'b0;
        r_n_w_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_comb begin
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    ovf_d     = ovf_q;
    if (capture) begin
      if (!m_valid_q || bus.m_ready) begin
        m_data_d  = bus.adc_din;
        m_valid_d = 1'b1;
      end else if (ovf_q != 8'hFF) begin
        ovf_d = ovf_q + 8'd1;
      end
    end else if (m_valid_q && bus.m_ready) begin
      m_valid_d = 1'b0;
    end
  end

  // cfg_idx leads by one cycle so the external table lookup is ready for the dout register.
  assign cfg_idx      = cfg_idx_d;
  assign bus.o_rest_n = rest_n_q;
  assign bus.cs_n     = cs_n_q;
  assign bus.r_n_w    = r_n_w_q;
  assign bus.adc_doe  = doe_q;
  assign bus.adc_dout = dout_q;
  assign bus.m_data   = m_data_q;
  assign bus.m_valid  = m_valid_q;
  assign ovf_cnt      = ovf_q;
  assign cfg_done     = (state_q == ST_CAPTURE);
  assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ad7760_seq_ctrl.sv
// tb/tb_ad7760_seq_ctrl.sv - self-checking bench for ad7760_seq_ctrl
module tb_ad7760_seq_ctrl;
  import ad7760_seq_ctrl_pkg::*;

  localparam int LO_C = 2, HI_C = 3, WR_C = 8, GAP_C = 8, SET_C = 6;

  logic        mclk = 1'b0;
  logic        i_rest, command;
  logic [3:0]  cfg_idx;
  logic [31:0] cfg_word;
  logic [7:0]  ovf_cnt;
  logic        cfg_done, busy;
  int          vectors = 0, miscompares = 0, ovf_exp = 0;

  ad7760_seq_ctrl_if #(.DW(16)) bus ();

  ad7760_seq_ctrl #(
    .DW(16), .NUM_CFG(2), .RST_LO_CYC(LO_C), .RST_HI_CYC(HI_C),
    .WR_CYC(WR_C), .GAP_CYC(GAP_C), .SETTLE_CYC(SET_C)
  ) dut (
    .mclk(mclk), .i_rest(i_rest), .command(command), .bus(bus),
    .cfg_idx(cfg_idx), .cfg_word(cfg_word), .ovf_cnt(ovf_cnt),
    .cfg_done(cfg_done), .busy(busy)
  );

  always #5 mclk = ~mclk;

  assign cfg_word = (cfg_idx == 4'd0) ? {CTRL1_ADDR, CTRL1_VAL} :
                    (cfg_idx == 4'd1) ? {CTRL2_ADDR, CTRL2_VAL} : 32'hDEAD_BEEF;

  task automatic test_reset();
    logic [54:0] got;
    i_rest = 1'b1; command = 1'b0;
    bus.drdy_n = 1'b1; bus.m_ready = 1'b0; bus.adc_din = '0;
    repeat (2) @(negedge mclk);
    got = {bus.o_rest_n, bus.cs_n, bus.r_n_w, bus.adc_doe, bus.adc_dout, cfg_idx,
           bus.m_data, bus.m_valid, ovf_cnt, cfg_done, busy};
    vectors++;
    if (got !== {3'b111, 1'b0, 16'h0, 4'h0, 16'h0, 1'b0, 8'h0, 2'b00}) begin
      miscompares++;
      $display("FAIL reset_state: got %h expected %h", got,
               {3'b111, 1'b0, 16'h0, 4'h0, 16'h0, 1'b0, 8'h0, 2'b00});
    end
    i_rest = 1'b0;
  endtask

  // Expected pin trace built from the phase list: reset low/high, then addr/gap/value/gap per pair, settle.
  task automatic run_config(input int drop_at);
    logic [18:0] exp_q[$];
    logic [18:0] a;
    logic [15:0] words[4];
    words = '{CTRL1_ADDR, CTRL1_VAL, CTRL2_ADDR, CTRL2_VAL};
    repeat (LO_C) exp_q.push_back({3'b010, 16'h0});
    repeat (HI_C) exp_q.push_back({3'b110, 16'h0});
    for (int w = 0; w < 4; w++) begin
      repeat (WR_C)  exp_q.push_back({3'b101, words[w]});
      repeat (GAP_C) exp_q.push_back({3'b110, 16'h0});
    end
    repeat (SET_C) exp_q.push_back({3'b110, 16'h0});
    command = 1'b1;
    foreach (exp_q[i]) begin
      @(negedge mclk);
      a = {bus.o_rest_n, bus.cs_n, bus.adc_doe, bus.adc_doe ? bus.adc_dout : 16'h0};
      vectors++;
      if (a !== exp_q[i] || bus.r_n_w !== 1'b1 || busy !== 1'b1 || cfg_done !== 1'b0) begin
        miscompares++;
        $display("FAIL cfg_trace[%0d]: got rst/cs/doe/dout=%h rnw=%b busy=%b done=%b expected %h rnw=1 busy=1 done=0",
                 i, a, bus.r_n_w, busy, cfg_done, exp_q[i]);
      end
      if (i == drop_at) command = 1'b0;
    end
    @(negedge mclk);
    vectors++;
    if (drop_at >= 0) begin
      if (busy !== 1'b0 || bus.cs_n !== 1'b1 || cfg_done !== 1'b0 || bus.r_n_w !== 1'b1) begin
        miscompares++;
        $display("FAIL cfg_end_idle: got busy=%b cs_n=%b done=%b rnw=%b expected 0 1 0 1",
                 busy, bus.cs_n, cfg_done, bus.r_n_w);
      end
      repeat (5) @(negedge mclk);
      vectors++;
      if (busy !== 1'b0 || bus.cs_n !== 1'b1) begin
        miscompares++;
        $display("FAIL cfg_stay_idle: got busy=%b cs_n=%b expected 0 1", busy, bus.cs_n);
      end
    end else begin
      if (busy !== 1'b1 || bus.cs_n !== 1'b0 || cfg_done !== 1'b1 || bus.r_n_w !== 1'b0 ||
          bus.adc_doe !== 1'b0) begin
        miscompares++;
        $display("FAIL cfg_end_capture: got busy=%b cs_n=%b done=%b rnw=%b doe=%b expected 1 0 1 0 0",
                 busy, bus.cs_n, cfg_done, bus.r_n_w, bus.adc_doe);
      end
    end
  endtask

  task automatic do_fall(input logic [15:0] v);
    bus.adc_din = v; bus.drdy_n = 1'b0;
    repeat (3) @(negedge mclk);
    bus.drdy_n = 1'b1;
    repeat (5) @(negedge mclk);
  endtask

  task automatic test_capture_single();
    bus.m_ready = 1'b1; bus.adc_din = 16'hA5C3; bus.drdy_n = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge mclk);
      if (c == 3) bus.drdy_n = 1'b1;
      vectors++;
      if (bus.m_valid !== (c == 4) || (c == 4 && bus.m_data !== 16'hA5C3)) begin
        miscompares++;
        $display("FAIL capture_single[%0d]: got valid=%b data=%h expected valid=%b data=a5c3",
                 c, bus.m_valid, bus.m_data, c == 4);
      end
    end
    bus.m_ready = 1'b0;
  endtask

  task automatic test_overflow_three();
    bus.m_ready = 1'b0;
    do_fall(16'd1); do_fall(16'd2); do_fall(16'd3);
    ovf_exp += 2;
    vectors++;
    if (bus.m_valid !== 1'b1 || bus.m_data !== 16'd1 || ovf_cnt !== 8'(ovf_exp)) begin
      miscompares++;
      $display("FAIL overflow_three: got valid=%b data=%h ovf=%0d expected 1 0001 %0d",
               bus.m_valid, bus.m_data, ovf_cnt, ovf_exp);
    end
    bus.m_ready = 1'b1;
    @(negedge mclk);
    bus.m_ready = 1'b0;
    vectors++;
    if (bus.m_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL overflow_drain: got valid=%b expected 0", bus.m_valid);
    end
  endtask

  // Random drdy/ready traffic against a one-slot sink model driven by arrival times.
  task automatic test_random_stream();
    bit mv = 1'b0, rdy, drain, arrive;
    logic [15:0] md = '0, pend = '0;
    int pipe = 0, low = 0, wait_n = 3;
    for (int k = 0; k <= 600; k++) begin
      @(negedge mclk);
      vectors++;
      if (bus.m_valid !== mv || (mv && bus.m_data !== md) || ovf_cnt !== 8'(ovf_exp)) begin
        miscompares++;
        $display("FAIL random_stream[%0d]: got valid=%b data=%h ovf=%0d expected %b %h %0d",
                 k, bus.m_valid, bus.m_data, ovf_cnt, mv, md, ovf_exp);
      end
      if (k == 600) break;
      rdy = 1'($urandom_range(0, 1));
      bus.m_ready = rdy;
      if (low > 0) begin
        low--;
        if (low == 0) bus.drdy_n = 1'b1;
      end
      if (wait_n > 0) wait_n--;
      else if (k < 580) begin
        pend = 16'($urandom); bus.adc_din = pend; bus.drdy_n = 1'b0;
        low = 3; pipe = 4; wait_n = $urandom_range(6, 12);
      end
      drain  = mv && rdy;
      arrive = 1'b0;
      if (pipe > 0) begin pipe--; arrive = (pipe == 0); end
      if (arrive) begin
        if (!mv || drain) begin mv = 1'b1; md = pend; end
        else if (ovf_exp < 255) ovf_exp++;
      end else if (drain) mv = 1'b0;
    end
    bus.drdy_n = 1'b1; bus.m_ready = 1'b1;
    @(negedge mclk);
    bus.m_ready = 1'b0;
    vectors++;
    if (bus.m_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL random_drain: got valid=%b expected 0", bus.m_valid);
    end
  endtask

  task automatic test_ovf_saturate();
    logic [15:0] first;
    first = 16'($urandom);
    bus.m_ready = 1'b0;
    do_fall(first);
    for (int n = 0; n < 300; n++) begin
      do_fall(16'($urandom));
      if (ovf_exp < 255) ovf_exp++;
      vectors++;
      if (ovf_cnt !== 8'(ovf_exp) || bus.m_data !== first || bus.m_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL ovf_saturate[%0d]: got ovf=%0d data=%h valid=%b expected %0d %h 1",
                 n, ovf_cnt, bus.m_data, bus.m_valid, ovf_exp, first);
      end
    end
    vectors++;
    if (ovf_cnt !== 8'd255) begin
      miscompares++;
      $display("FAIL ovf_final: got %0d expected 255", ovf_cnt);
    end
    bus.m_ready = 1'b1;
    @(negedge mclk);
    bus.m_ready = 1'b0;
  endtask

  task automatic test_command_stop_capture();
    logic [15:0] v;
    v = 16'($urandom);
    bus.adc_din = v; bus.drdy_n = 1'b0;
    repeat (3) @(negedge mclk);
    bus.drdy_n = 1'b1; command = 1'b0;
    @(negedge mclk);
    vectors++;
    if (bus.cs_n !== 1'b1 || bus.r_n_w !== 1'b1 || busy !== 1'b0 || cfg_done !== 1'b0 ||
        bus.m_valid !== 1'b1 || bus.m_data !== v) begin
      miscompares++;
      $display("FAIL stop_capture: got cs_n=%b rnw=%b busy=%b done=%b valid=%b data=%h expected 1 1 0 0 1 %h",
               bus.cs_n, bus.r_n_w, busy, cfg_done, bus.m_valid, bus.m_data, v);
    end
    repeat (3) @(negedge mclk);
    vectors++;
    if (bus.m_valid !== 1'b1 || bus.m_data !== v) begin
      miscompares++;
      $display("FAIL hold_after_stop: got valid=%b data=%h expected 1 %h", bus.m_valid, bus.m_data, v);
    end
    bus.m_ready = 1'b1;
    @(negedge mclk);
    bus.m_ready = 1'b0;
    do_fall(16'($urandom));
    vectors++;
    if (bus.m_valid !== 1'b0 || ovf_cnt !== 8'(ovf_exp)) begin
      miscompares++;
      $display("FAIL idle_ignores_drdy: got valid=%b ovf=%0d expected 0 %0d", bus.m_valid, ovf_cnt, ovf_exp);
    end
  endtask

  task automatic test_reset_mid_write();
    logic [54:0] got;
    command = 1'b1;
    repeat (24) @(negedge mclk);
    vectors++;
    if (bus.cs_n !== 1'b0 || bus.adc_doe !== 1'b1 || bus.adc_dout !== CTRL1_VAL) begin
      miscompares++;
      $display("FAIL in_wr_val: got cs_n=%b doe=%b dout=%h expected 0 1 %h",
               bus.cs_n, bus.adc_doe, bus.adc_dout, CTRL1_VAL);
    end
    #2 i_rest = 1'b1;
    #1;
    ovf_exp = 0;
    got = {bus.o_rest_n, bus.cs_n, bus.r_n_w, bus.adc_doe, bus.adc_dout, cfg_idx,
           bus.m_data, bus.m_valid, ovf_cnt, cfg_done, busy};
    vectors++;
    if (got !== {3'b111, 1'b0, 16'h0, 4'h0, 16'h0, 1'b0, 8'h0, 2'b00}) begin
      miscompares++;
      $display("FAIL async_reset: got %h expected %h", got,
               {3'b111, 1'b0, 16'h0, 4'h0, 16'h0, 1'b0, 8'h0, 2'b00});
    end
    @(negedge mclk);
    i_rest = 1'b0;
    run_config(-1);
  endtask

  initial begin
    test_reset();
    run_config(-1);
    test_capture_single();
    test_overflow_three();
    test_random_stream();
    test_ovf_saturate();
    test_command_stop_capture();
    run_config(15);
    test_reset_mid_write();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
